// File: rtl/rr_output_arbiter_pkg.sv
// Shared definitions for the star-router output arbiter: FSM encoding and
// default sizing for one output port.
package rr_output_arbiter_pkg;

    localparam int unsigned N_DEF       = 10;
    localparam int unsigned ID_W_DEF    = 4;
    localparam int unsigned CREDITS_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

endpackage : rr_output_arbiter_pkg

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick
    import rr_output_arbiter_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned ID_W = ID_W_DEF
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    sel,
    output logic [ID_W-1:0] sel_id,
    output logic            any
);

    int unsigned     idx;
    logic [ID_W-1:0] idx_b;

    // Scan ptr, ptr+1, ... N-1, 0, ... ptr-1 and keep the first hit
    always_comb begin
        sel    = '0;
        sel_id = '0;
        any    = 1'b0;
        idx    = 0;
        idx_b  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx   = (32'(ptr) + i) % N;
            idx_b = ID_W'(idx);
            if (!any && req[idx_b]) begin
                any        = 1'b1;
                sel[idx_b] = 1'b1;
                sel_id     = idx_b;
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_output_arbiter.sv
// Per-output round-robin packet arbiter with wormhole locking and a
// downstream credit counter.
module rr_output_arbiter
    import rr_output_arbiter_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned ID_W    = ID_W_DEF,
    parameter int unsigned CREDITS = CREDITS_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     flit_valid,
    input  logic [N-1:0]     flit_tail,
    input  logic             credit_in,
    output logic [N-1:0]     gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             locked,
    output logic             fwd,
    output logic [CNT_W-1:0] credit_cnt,
    output logic             credit_err
);

    arb_state_t      state;
    logic [ID_W-1:0] ptr;
    logic [N-1:0]    pick_sel;
    logic [ID_W-1:0] pick_id;
    logic            pick_any;
    logic            tail_fwd;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .sel    (pick_sel),
        .sel_id (pick_id),
        .any    (pick_any)
    );

    // A flit moves only while locked, with credit, and never in a reset cycle
    always_comb begin
        fwd      = !rst && locked && flit_valid[gnt_id] && (credit_cnt != '0);
        tail_fwd = fwd && flit_tail[gnt_id];
    end

    // Arbitration FSM, grant/pointer registers and credit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            gnt_id     <= '0;
            locked     <= 1'b0;
            ptr        <= '0;
            credit_cnt <= CNT_W'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            // Credit accounting; a simultaneous fwd and return cancel out
            case ({fwd, credit_in})
                2'b10: credit_cnt <= credit_cnt - CNT_W'(1);
                2'b01: begin
                    if (credit_cnt == CNT_W'(CREDITS)) begin
                        credit_err <= 1'b1;
                    end else begin
                        credit_cnt <= credit_cnt + CNT_W'(1);
                    end
                end
                default: credit_cnt <= credit_cnt;
            endcase

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt    <= pick_sel;
                        gnt_id <= pick_id;
                        locked <= 1'b1;
                        state  <= LOCK;
                    end
                end
                LOCK: begin
                    if (tail_fwd) begin
                        gnt    <= '0;
                        gnt_id <= '0;
                        locked <= 1'b0;
                        ptr    <= (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + ID_W'(1);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : rr_output_arbiter

// File: tb/tb_rr_output_arbiter.sv
// Directed self-checking bench for rr_output_arbiter.
module tb_rr_output_arbiter;

    localparam int unsigned N     = 10;
    localparam int unsigned ID_W  = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0]     flit_valid;
    logic [N-1:0]     flit_tail;
    logic             credit_in;
    logic [N-1:0]     gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             locked;
    logic             fwd;
    logic [CNT_W-1:0] credit_cnt;
    logic             credit_err;

    int n_cmp = 0;
    int n_err = 0;

    rr_output_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .flit_valid (flit_valid),
        .flit_tail  (flit_tail),
        .credit_in  (credit_in),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .locked     (locked),
        .fwd        (fwd),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Grant edge followed by an nflits packet with credit returned on every flit
    task automatic grant_and_send(input int unsigned id, input int unsigned nflits);
        logic [N-1:0] oh;
        oh = N'(1) << id;
        tick();
        check($sformatf("gnt_%0d", id), 32'(gnt), 32'(oh));
        check($sformatf("gnt_id_%0d", id), 32'(gnt_id), id);
        check($sformatf("locked_%0d", id), 32'(locked), 1);
        for (int unsigned f = 0; f < nflits; f++) begin
            flit_valid = oh;
            flit_tail  = (f == nflits - 1) ? oh : '0;
            credit_in  = 1'b1;
            #1;
            check($sformatf("fwd_%0d_f%0d", id, f), 32'(fwd), 1);
            tick();
        end
        check($sformatf("rel_gnt_%0d", id), 32'(gnt), 0);
        check($sformatf("rel_locked_%0d", id), 32'(locked), 0);
        check($sformatf("rel_cnt_%0d", id), 32'(credit_cnt), 4);
        flit_valid = '0;
        flit_tail  = '0;
        credit_in  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        flit_valid = '0;
        flit_tail  = '0;
        credit_in  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset
        for (int c = 0; c < 3; c++) begin
            tick();
            check("idle_gnt", 32'(gnt), 0);
            check("idle_locked", 32'(locked), 0);
            check("idle_cnt", 32'(credit_cnt), 4);
            check("idle_fwd", 32'(fwd), 0);
        end
        check("idle_gnt_id", 32'(gnt_id), 0);
        check("idle_err", 32'(credit_err), 0);

        // Round robin among 2, 5, 9 with ptr starting at 0
        req = 10'b1000100100;
        grant_and_send(2, 2);
        grant_and_send(5, 2);
        grant_and_send(9, 2);
        grant_and_send(2, 2);
        req = '0;
        tick();
        check("rr_done_gnt", 32'(gnt), 0);
        check("rr_err", 32'(credit_err), 0);

        // Grant 8 so ptr becomes 9, then 9 wins over 0 and holds while req[9] drops
        req = 10'b0100000000;
        grant_and_send(8, 1);
        req = 10'b1000000001;
        tick();
        check("wrap_gnt9", 32'(gnt), 32'(10'b1000000000));
        req        = 10'b0000000001;
        flit_valid = 10'b1000000000;
        credit_in  = 1'b1;
        #1;
        check("wrap_fwd1", 32'(fwd), 1);
        tick();
        check("wrap_hold", 32'(gnt), 32'(10'b1000000000));
        check("wrap_hold_locked", 32'(locked), 1);
        flit_tail = 10'b1000000000;
        #1;
        check("wrap_fwd2", 32'(fwd), 1);
        tick();
        check("wrap_rel", 32'(gnt), 0);
        flit_valid = '0;
        flit_tail  = '0;
        credit_in  = 1'b0;
        req        = 10'b0000000011;
        grant_and_send(0, 1);
        // ptr is now 1, so input 1 beats input 0
        grant_and_send(1, 1);
        req = '0;
        tick();
        check("wrap_idle", 32'(gnt), 0);

        // Credit stall: 6-flit packet on input 4, no credit returned
        req = 10'b0000010000;
        tick();
        check("stall_gnt", 32'(gnt_id), 4);
        req        = '0;
        flit_valid = 10'b0000010000;
        for (int f = 0; f < 4; f++) begin
            #1;
            check($sformatf("stall_fwd%0d", f), 32'(fwd), 1);
            check($sformatf("stall_cnt%0d", f), 32'(credit_cnt), 32'(4 - f));
            tick();
        end
        #1;
        check("stall_cnt0", 32'(credit_cnt), 0);
        check("stall_fwd_off", 32'(fwd), 0);
        tick();
        check("stall_hold_gnt", 32'(gnt), 32'(10'b0000010000));
        check("stall_hold_fwd", 32'(fwd), 0);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        #1;
        check("stall_cnt1", 32'(credit_cnt), 1);
        check("stall_fwd5", 32'(fwd), 1);
        tick();
        check("stall_cnt_back0", 32'(credit_cnt), 0);
        check("stall_fwd_off2", 32'(fwd), 0);
        flit_tail = 10'b0000010000;
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        #1;
        check("stall_tail_fwd", 32'(fwd), 1);
        tick();
        check("stall_rel", 32'(locked), 0);
        check("stall_rel_cnt", 32'(credit_cnt), 0);
        flit_valid = '1;
        flit_tail  = '0;
        credit_in  = 1'b1;
        #1;
        check("idle_no_fwd", 32'(fwd), 0);
        tick();
        flit_valid = '0;
        tick();
        credit_in = 1'b0;
        check("refill_cnt2", 32'(credit_cnt), 2);

        // Simultaneous fwd and credit_in at 2, then overflow at 4
        req = 10'b0001000000;
        tick();
        check("sim_gnt", 32'(gnt_id), 6);
        req        = '0;
        flit_valid = 10'b0001000000;
        credit_in  = 1'b1;
        #1;
        check("sim_fwd", 32'(fwd), 1);
        tick();
        check("sim_cnt", 32'(credit_cnt), 2);
        flit_tail = 10'b0001000000;
        tick();
        check("sim_rel", 32'(locked), 0);
        check("sim_cnt2", 32'(credit_cnt), 2);
        flit_valid = '0;
        flit_tail  = '0;
        tick();
        check("ret_cnt3", 32'(credit_cnt), 3);
        tick();
        check("ret_cnt4", 32'(credit_cnt), 4);
        check("ret_err0", 32'(credit_err), 0);
        tick();
        credit_in = 1'b0;
        check("ovf_cnt", 32'(credit_cnt), 4);
        check("ovf_err", 32'(credit_err), 1);
        tick();
        check("ovf_sticky", 32'(credit_err), 1);

        // Mid-packet reset on a 4-flit packet from input 5 (ptr is 7)
        req = 10'b0000100000;
        tick();
        check("mr_gnt", 32'(gnt_id), 5);
        flit_valid = 10'b0000100000;
        #1;
        check("mr_fwd1", 32'(fwd), 1);
        tick();
        check("mr_cnt3", 32'(credit_cnt), 3);
        rst = 1'b1;
        #1;
        check("mr_fwd_in_rst", 32'(fwd), 0);
        tick();
        rst        = 1'b0;
        flit_valid = '0;
        check("mr_gnt0", 32'(gnt), 0);
        check("mr_locked0", 32'(locked), 0);
        check("mr_cnt4", 32'(credit_cnt), 4);
        check("mr_err0", 32'(credit_err), 0);

        // ptr back at 0: input 3 wins over 9; single-flit packet
        req = 10'b1000001000;
        tick();
        check("sf_gnt", 32'(gnt), 32'(10'b0000001000));
        req        = '0;
        flit_valid = 10'b0000001000;
        flit_tail  = 10'b0000001000;
        #1;
        check("sf_fwd", 32'(fwd), 1);
        tick();
        flit_valid = '0;
        flit_tail  = '0;
        check("sf_rel_gnt", 32'(gnt), 0);
        check("sf_rel_locked", 32'(locked), 0);
        check("sf_cnt", 32'(credit_cnt), 3);
        tick();
        check("sf_idle", 32'(gnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rr_output_arbiter
